// File: rtl/nios2_debug_ocimem_ctrl_if.sv
// Avalon-MM debug-slave bus between the CPU and the on-chip debug memory.
interface nios2_debug_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport slave (
    input  address, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );

  modport master (
    output address, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );
endinterface

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Debug RAM shared between the JTAG monitor and the CPU debug-slave port.
// The CPU always wins the single RAM port; JTAG waits for idle cycles.
module nios2_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  nios2_debug_ocimem_ctrl_if.slave avs,
  output logic [31:0]           MonDReg,
  output logic [ADDR_W-1:0]     MonAReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {C_IDLE, C_RDW} c_state_t;
  typedef enum logic [1:0] {J_IDLE, J_RDP, J_RDD, J_WRP} j_state_t;

  c_state_t          c_state;
  j_state_t          j_state;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_q;
  logic [31:0]       rd_hold;
  logic [31:0]       jwdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wd;
  logic [3:0]        ram_be;
  logic              ram_we;
  logic              cpu_own;
  logic              strobe_any;
  logic              jdo_unused;

  assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

  // Port arbitration: any CPU request takes the RAM this cycle.
  assign cpu_own    = avs.read | avs.write;
  assign strobe_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  always_comb begin
    ram_addr = MonAReg;
    ram_wd   = jwdata;
    ram_be   = 4'hF;
    ram_we   = (j_state == J_WRP);
    if (cpu_own) begin
      ram_addr = avs.address;
      ram_wd   = avs.writedata;
      ram_be   = avs.byteenable;
      // read wins a simultaneous read/write; writes without debugaccess are dropped
      ram_we   = avs.write & ~avs.read & avs.debugaccess;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ram_q <= '0;
    else          ram_q <= mem[ram_addr];
  end

  // CPU side: one wait cycle per read, writes complete immediately.
  assign avs.waitrequest = avs.read & (c_state == C_IDLE);
  assign avs.readdata    = (c_state == C_RDW) ? ram_q : rd_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_state <= C_IDLE;
      rd_hold <= '0;
    end else begin
      case (c_state)
        C_IDLE: if (avs.read) c_state <= C_RDW;
        C_RDW: begin
          rd_hold <= ram_q;
          c_state <= C_IDLE;
        end
        default: c_state <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      j_state       <= J_IDLE;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      jwdata        <= '0;
    end else begin
      // Strobes arriving mid-operation are dropped and flagged.
      if (j_state != J_IDLE && strobe_any) monitor_error <= 1'b1;
      case (j_state)
        J_IDLE: begin
          if (take_action_ocimem_a) begin
            MonAReg       <= jdo[17 +: ADDR_W];
            monitor_error <= 1'b0;
            if (jdo[35]) begin
              monitor_ready <= 1'b0;
              j_state       <= J_RDP;
            end else begin
              monitor_ready <= 1'b1;
            end
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            j_state       <= J_RDP;
          end else if (take_action_ocimem_b) begin
            jwdata        <= jdo[34:3];
            monitor_ready <= 1'b0;
            j_state       <= J_WRP;
          end
        end
        J_RDP: if (!cpu_own) j_state <= J_RDD;
        J_RDD: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          MonAReg       <= MonAReg + 1'b1;
          j_state       <= J_IDLE;
        end
        J_WRP: begin
          if (!cpu_own) begin
            monitor_ready <= 1'b1;
            MonAReg       <= MonAReg + 1'b1;
            j_state       <= J_IDLE;
          end
        end
        default: j_state <= J_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Directed bench for the debug memory controller: JTAG ops, CPU ops, arbitration, overrun, reset.
module tb_nios2_debug_ocimem_ctrl;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [37:0]   jdo = '0;
  logic          ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready, monitor_error;
  int            total = 0, bad = 0;
  logic [31:0]   rd;
  int            waits;
  logic          wr_wait;

  nios2_debug_ocimem_ctrl_if #(.ADDR_W(AW)) avs ();

  nios2_debug_ocimem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a),
    .take_action_ocimem_b(ta_b), .avs(avs),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk_a(input logic [AW-1:0] a, input logic rdf);
    logic [37:0] j;
    j = '0; j[35] = rdf; j[17 +: AW] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  // Drives strobes for one cycle; returns at the negedge after the accepting edge.
  task automatic strobe(input logic a, input logic na, input logic b, input logic [37:0] j);
    @(negedge clk);
    ta_a = a; tna_a = na; ta_b = b; jdo = j;
    @(negedge clk);
    ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, output logic wt);
    @(negedge clk);
    avs.address = a; avs.writedata = d; avs.byteenable = be; avs.debugaccess = dbg; avs.write = 1'b1;
    #1 wt = avs.waitrequest;
    @(negedge clk);
    avs.write = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output logic [31:0] d, output int w);
    @(negedge clk);
    avs.address = a; avs.read = 1'b1;
    w = 0; d = 32'hx;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (!avs.waitrequest) begin d = avs.readdata; break; end
      w++;
      @(negedge clk);
    end
    avs.read = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL rst_mondreg got=%h exp=0", MonDReg); end
    total++; if (MonAReg !== 8'h0) begin bad++; $display("FAIL rst_monareg got=%h exp=0", MonAReg); end
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", monitor_ready); end
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", monitor_error); end
    total++; if (avs.readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata got=%h exp=0", avs.readdata); end
    total++; if (avs.waitrequest !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b exp=0", avs.waitrequest); end
    reset_n = 1'b1;
  endtask

  task automatic test_cpu_write_jtag_read;
    cpu_write(8'h10, 32'hDEADBEEF, 4'hF, 1'b1, wr_wait);
    total++; if (wr_wait !== 1'b0) begin bad++; $display("FAIL wr_wait got=%b exp=0", wr_wait); end
    strobe(1'b1, 1'b0, 1'b0, mk_a(8'h10, 1'b1));
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL jrd_ready_c1 got=%b exp=0", monitor_ready); end
    @(negedge clk);
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL jrd_ready_c2 got=%b exp=0", monitor_ready); end
    @(negedge clk);
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL jrd_ready_c3 got=%b exp=1", monitor_ready); end
    total++; if (MonDReg !== 32'hDEADBEEF) begin bad++; $display("FAIL jrd_data got=%h exp=deadbeef", MonDReg); end
    total++; if (MonAReg !== 8'h11) begin bad++; $display("FAIL jrd_addr got=%h exp=11", MonAReg); end
  endtask

  task automatic test_jtag_write_wrap;
    strobe(1'b1, 1'b0, 1'b0, mk_a(8'hFE, 1'b0));
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL lda_ready got=%b exp=1", monitor_ready); end
    total++; if (MonAReg !== 8'hFE) begin bad++; $display("FAIL lda_addr got=%h exp=fe", MonAReg); end
    strobe(1'b0, 1'b0, 1'b1, mk_b(32'h11111111));
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL jwr_ready_c1 got=%b exp=0", monitor_ready); end
    @(negedge clk);
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL jwr_ready_c2 got=%b exp=1", monitor_ready); end
    total++; if (MonAReg !== 8'hFF) begin bad++; $display("FAIL jwr_addr1 got=%h exp=ff", MonAReg); end
    strobe(1'b0, 1'b0, 1'b1, mk_b(32'h22222222));
    @(negedge clk);
    total++; if (MonAReg !== 8'h00) begin bad++; $display("FAIL jwr_wrap got=%h exp=00", MonAReg); end
    cpu_read(8'hFE, rd, waits);
    total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL rd_fe got=%h exp=11111111", rd); end
    total++; if (waits !== 1) begin bad++; $display("FAIL rd_fe_waits got=%0d exp=1", waits); end
    cpu_read(8'hFF, rd, waits);
    total++; if (rd !== 32'h22222222) begin bad++; $display("FAIL rd_ff got=%h exp=22222222", rd); end
    total++; if (waits !== 1) begin bad++; $display("FAIL rd_ff_waits got=%0d exp=1", waits); end
  endtask

  task automatic test_cpu_starve;
    cpu_write(8'h30, 32'h30303030, 4'hF, 1'b1, wr_wait);
    @(negedge clk);
    ta_a = 1'b1; jdo = mk_a(8'h30, 1'b1);
    avs.address = 8'hFE; avs.read = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      ta_a = 1'b0;
      total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL starve_ready n=%0d got=%b exp=0", n, monitor_ready); end
      if (n % 2 == 1) begin
        total++; if (avs.waitrequest !== 1'b0) begin bad++; $display("FAIL starve_wait n=%0d got=%b exp=0", n, avs.waitrequest); end
        total++; if (avs.readdata !== 32'h11111111) begin bad++; $display("FAIL starve_rdata n=%0d got=%h exp=11111111", n, avs.readdata); end
      end
      if (n == 6) avs.read = 1'b0;
    end
    @(negedge clk);
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL starve_ready_late got=%b exp=0", monitor_ready); end
    @(negedge clk);
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL starve_done got=%b exp=1", monitor_ready); end
    total++; if (MonDReg !== 32'h30303030) begin bad++; $display("FAIL starve_data got=%h exp=30303030", MonDReg); end
    total++; if (MonAReg !== 8'h31) begin bad++; $display("FAIL starve_addr got=%h exp=31", MonAReg); end
  endtask

  task automatic test_overrun;
    cpu_write(8'h40, 32'h40404040, 4'hF, 1'b1, wr_wait);
    cpu_write(8'h41, 32'h41414141, 4'hF, 1'b1, wr_wait);
    @(negedge clk);
    ta_a = 1'b1; jdo = mk_a(8'h40, 1'b1);
    @(negedge clk);
    ta_a = 1'b0; ta_b = 1'b1; jdo = mk_b(32'h99999999);
    @(negedge clk);
    ta_b = 1'b0;
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL ovr_error got=%b exp=1", monitor_error); end
    @(negedge clk);
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL ovr_ready got=%b exp=1", monitor_ready); end
    total++; if (MonDReg !== 32'h40404040) begin bad++; $display("FAIL ovr_data got=%h exp=40404040", MonDReg); end
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", monitor_error); end
    cpu_read(8'h41, rd, waits);
    total++; if (rd !== 32'h41414141) begin bad++; $display("FAIL ovr_dropped got=%h exp=41414141", rd); end
    strobe(1'b1, 1'b0, 1'b0, mk_a(8'h00, 1'b0));
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", monitor_error); end
  endtask

  task automatic test_priority;
    strobe(1'b1, 1'b0, 1'b1, mk_a(8'h60, 1'b0));
    @(negedge clk);
    total++; if (MonAReg !== 8'h60) begin bad++; $display("FAIL prio_addr got=%h exp=60", MonAReg); end
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL prio_ready got=%b exp=1", monitor_ready); end
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL prio_error got=%b exp=0", monitor_error); end
  endtask

  task automatic test_cpu_write_perm;
    cpu_write(8'h20, 32'h12345678, 4'hF, 1'b1, wr_wait);
    cpu_write(8'h20, 32'hCAFEF00D, 4'hF, 1'b0, wr_wait);
    total++; if (wr_wait !== 1'b0) begin bad++; $display("FAIL perm_wait got=%b exp=0", wr_wait); end
    cpu_read(8'h20, rd, waits);
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL perm_kept got=%h exp=12345678", rd); end
    cpu_write(8'h20, 32'hAAAABBBB, 4'b0011, 1'b1, wr_wait);
    cpu_read(8'h20, rd, waits);
    total++; if (rd !== 32'h1234BBBB) begin bad++; $display("FAIL byteen got=%h exp=1234bbbb", rd); end
  endtask

  task automatic test_reset_mid;
    strobe(1'b1, 1'b0, 1'b0, mk_a(8'h50, 1'b1));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL mrst_mondreg got=%h exp=0", MonDReg); end
    total++; if (MonAReg !== 8'h0) begin bad++; $display("FAIL mrst_monareg got=%h exp=0", MonAReg); end
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL mrst_ready got=%b exp=0", monitor_ready); end
    total++; if (avs.readdata !== 32'h0) begin bad++; $display("FAIL mrst_readdata got=%h exp=0", avs.readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, mk_a(8'h07, 1'b0));
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL mrst_next_ready got=%b exp=1", monitor_ready); end
    total++; if (MonAReg !== 8'h07) begin bad++; $display("FAIL mrst_next_addr got=%h exp=07", MonAReg); end
  endtask

  initial begin
    avs.address = '0; avs.read = 1'b0; avs.write = 1'b0; avs.writedata = '0;
    avs.byteenable = 4'hF; avs.debugaccess = 1'b0;
    test_reset;
    test_cpu_write_jtag_read;
    test_jtag_write_wrap;
    test_cpu_starve;
    test_overrun;
    test_priority;
    test_cpu_write_perm;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nios2_debug_ocimem_ctrl.md
Name: nios2_debug_ocimem_ctrl

Overview:
- On-chip debug memory controller that consumes the decoded JTAG command strobes and the 38-bit `jdo` payload from the debug-slave sysclk stage.
- Holds a DEPTH x 32 debug RAM that is shared between the JTAG debugger and the CPU's Avalon debug-slave port.
- Returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave wrapper for shift-out over JTAG.
- The CPU port has priority; JTAG accesses are deferred to cycles where the CPU port is idle.

Parameters:
- ADDR_W, 8, word-address width of the debug RAM; legal range 1..17.
- DEPTH, 2**ADDR_W, RAM depth in 32-bit words; derived, not overridden.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- jdo  in  38  JTAG data from the sysclk stage, stable while a strobe is high.
- take_action_ocimem_a  in  1  load address; optionally read.
- take_no_action_ocimem_a  in  1  read at the current address.
- take_action_ocimem_b  in  1  write data at the current address.
- address  in  ADDR_W  CPU Avalon word address.
- read  in  1  CPU read request.
- write  in  1  CPU write request.
- writedata  in  32  CPU write data.
- byteenable  in  4  CPU byte lanes.
- debugaccess  in  1  CPU write permission.
- readdata  out  32  CPU read data.
- waitrequest  out  1  CPU stall.
- MonDReg  out  32  monitor data register to the JTAG tck stage.
- MonAReg  out  ADDR_W  current JTAG word address.
- monitor_ready  out  1  last JTAG operation complete.
- monitor_error  out  1  sticky command-overrun flag.

Behaviour:
- Single clock domain. `reset_n` low asynchronously clears everything:
  - outputs: `MonDReg`=0, `MonAReg`=0, `monitor_ready`=0, `monitor_error`=0, `readdata`=0;
  - both FSMs return to IDLE;
  - RAM contents are not reset.
- Debug RAM: single port, synchronous read. An address presented in cycle N gives data in cycle N+1. Writes honour `byteenable` for CPU accesses; JTAG writes are always full-word.
- Port ownership: the CPU owns the RAM in any cycle where `read` or `write` is high. Otherwise a pending JTAG access takes the RAM.
- CPU FSM, states C_IDLE and C_RDW:
  - `read` in C_IDLE: `waitrequest`=1 (combinational), RAM addressed, go to C_RDW.
  - C_RDW: `waitrequest`=0, `readdata` = RAM output (registered), return to C_IDLE. Read latency is 1 wait cycle.
  - `write`: `waitrequest`=0, same cycle. The RAM is written only if `debugaccess`=1; otherwise the write is accepted and silently dropped.
  - `read` and `write` together is illegal; `read` wins.
- JTAG commands: decoded when FSM = J_IDLE. Priority is a > no_action_a > b; lower-priority strobes in the same cycle are ignored, with no error.
  - `take_action_ocimem_a`: `MonAReg` <= `jdo`[17+ADDR_W-1:17]. If `jdo`[35]=1, go to J_RDP; else `monitor_ready` <= 1. Always clears `monitor_error`.
  - `take_no_action_ocimem_a`: go to J_RDP.
  - `take_action_ocimem_b`: capture `jdo`[34:3] as write data, go to J_WRP.
  - Every accepted command clears `monitor_ready` on the same edge, except a non-reading address load, which sets it.
- JTAG FSM transitions:
  - J_RDP: on the first port-free cycle, drive the RAM at `MonAReg`, go to J_RDD.
  - J_RDD: `MonDReg` <= RAM output, `monitor_ready` <= 1, `MonAReg` <= `MonAReg`+1, go to J_IDLE.
  - J_WRP: on the first port-free cycle, write the RAM at `MonAReg`, then `monitor_ready` <= 1, `MonAReg` += 1, go to J_IDLE.
- Uncontended latency, with the command strobe at cycle C:
  - read: `MonDReg`/`monitor_ready` valid from C+3;
  - write: RAM written at C+1, `monitor_ready` high from C+2.
- `MonAReg` increments modulo DEPTH: 2**ADDR_W-1 wraps to 0.
- Overrun: any strobe while the JTAG FSM is not J_IDLE is dropped and sets `monitor_error`. The in-flight operation completes normally. The error is cleared only by an accepted `take_action_ocimem_a` or by reset.
- Continuous CPU traffic may starve JTAG indefinitely. This is accepted behaviour, and no timeout is implemented.

Test Plan:
- Reset mid JTAG read (assert `reset_n` during J_RDD) -> all outputs 0 immediately; next command processed from J_IDLE.
- CPU write 0xDEADBEEF @0x10 with `debugaccess`=1, then `ocimem_a` with `jdo` addr=0x10 and `jdo`[35]=1 -> `MonDReg`=0xDEADBEEF and `monitor_ready`=1 at C+3; `MonAReg`=0x11.
- `ocimem_a` addr=0xFE (`jdo`[35]=0), then `ocimem_b` 0x11111111 and `ocimem_b` 0x22222222 -> CPU reads 0xFE=0x11111111 and 0xFF=0x22222222 with 1 wait cycle each; `MonAReg` wraps to 0x00.
- Hold CPU `read` high for 6 cycles while a JTAG read is pending -> JTAG RAM access is deferred until `read` drops; `monitor_ready` rises 2 cycles later; CPU `readdata` is unaffected.
- `take_action_ocimem_b` while in J_RDP -> `monitor_error`=1, write dropped, pending read completes; next `ocimem_a` clears `monitor_error`.
- CPU write 0xCAFEF00D @0x20 with `debugaccess`=0 and `waitrequest`=0 -> RAM @0x20 unchanged. Separately, write with `byteenable`=0b0011 -> only the low 16 bits update.
